ws2812_frame_arbiter: RTL
=========================

WS2812_FRAME_ARBITER -- requirements
Module: ws2812_frame_arbiter

Interface
REQ-001 SHALL have parameter SOURCES, default 2, meaning number of pattern sources sharing one strip driver (2..4).
REQ-002 SHALL have parameter LEDS, default 32, meaning LEDs per frame; frame length is LEDS*3 bytes.
REQ-003 SHALL have parameter LATCH_CYCLES, default 800000, meaning idle clocks after a frame before the next grant (WS2812 latch gap).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port src_trigger  input  SOURCES  per-source "frame ready" level.
REQ-007 SHALL have port src_color  input  SOURCES*8  per-source current byte; source n occupies bits [8n+7:8n].
REQ-008 SHALL have port src_data_request  output  SOURCES  per-source byte-consumed strobe.
REQ-009 SHALL have port drv_start  output  1  one-cycle frame-start pulse to the strip driver.
REQ-010 SHALL have port drv_data_request  input  1  driver consumes drv_color this cycle.
REQ-011 SHALL have port drv_color  output  8  byte presented to the driver.
REQ-012 SHALL have port grant_id  output  $clog2(SOURCES)  currently or last granted source.
REQ-013 SHALL have port frame_active  output  1  high in GRANT and STREAM states.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, STREAM, LATCH.
REQ-015 IDLE SHALL go to GRANT on the first cycle any src_trigger bit is high; the winner is latched into grant_id on that transition.
REQ-016 Winner selection SHALL be round-robin: search starts at (last grant + 1) mod SOURCES, wraps, first set trigger wins.
REQ-017 GRANT SHALL last exactly one cycle, assert drv_start for that cycle only, clear byte counter, then go to STREAM.
REQ-018 In STREAM drv_color SHALL equal src_color of grant_id combinationally; elsewhere drv_color SHALL be 0.
REQ-019 In STREAM src_data_request[grant_id] SHALL equal drv_data_request combinationally; all other bits and all bits outside STREAM SHALL be 0.
REQ-020 Byte counter width SHALL be $clog2(LEDS*3); it increments on each drv_data_request in STREAM.
REQ-021 When drv_data_request occurs with counter == LEDS*3-1, FSM SHALL go to LATCH and load latch counter with LATCH_CYCLES-1.
REQ-022 LATCH SHALL decrement each cycle and go to IDLE the cycle after the counter reads 0 (exactly LATCH_CYCLES cycles in LATCH).
REQ-023 src_trigger SHALL be sampled only in IDLE; triggers asserted in GRANT/STREAM/LATCH are not queued and are honoured only if still high in IDLE.
REQ-024 A granted source dropping src_trigger mid-frame SHALL NOT abort the frame.
REQ-025 drv_data_request in IDLE, GRANT or LATCH SHALL be ignored (no forward, no count).

Reset
REQ-026 rst low SHALL asynchronously force state IDLE, byte and latch counters 0, grant_id 0, round-robin pointer so that source 0 is searched first, drv_start 0, frame_active 0.
REQ-027 Reset mid-STREAM SHALL discard the partial frame; the next frame SHALL restart at byte 0 with a new drv_start.

Configuration
REQ-028 Macro WS2812_ARB_FIXED_PRIORITY_EN defined: selection SHALL be fixed priority, lowest index wins, no pointer state.
REQ-029 Macro undefined: selection SHALL be round-robin per REQ-016.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding and the WS2812 byte-per-LED constant (3).
REQ-031 Winner selection SHALL be one sub-module ws2812_rr_select (trigger vector, pointer in; index, valid out), containing both macro variants.

Verification (SOURCES=2, LEDS=2, LATCH_CYCLES=4)
REQ-032 src_trigger=01, src_color0=0x5A, six drv_data_request pulses -> drv_start one cycle after trigger, six src_data_request[0] pulses, none on [1], drv_color=0x5A, LATCH 4 cycles, then IDLE.
REQ-033 src_trigger=11 held for three frames -> grant_id 0,1,0; with WS2812_ARB_FIXED_PRIORITY_EN -> 0,0,0.
REQ-034 drv_data_request pulsed in IDLE and LATCH -> src_data_request stays 00, frame length unchanged.
REQ-035 rst low after 3 bytes in STREAM -> all outputs 0 immediately; next trigger yields drv_start and full 6-byte frame.
REQ-036 src_trigger=10 raised during LATCH -> grant to source 1 on first IDLE cycle, drv_start next cycle.
REQ-037 source 0 drops trigger after byte 2 -> frame completes all 6 bytes to source 0.

Source files
------------

// File: rtl/ws2812_frame_arbiter_pkg.sv
// Shared definitions for the WS2812 frame arbiter: FSM encoding and
// strip geometry constants.
package ws2812_frame_arbiter_pkg;

  // Each WS2812 LED takes one byte each of G, R and B.
  localparam int BYTES_PER_LED = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_STREAM = 2'd2,
    ST_LATCH  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ws2812_rr_select.sv
// Winner selection among frame-ready sources.
// Default: round-robin, search begins at ptr and wraps.
// WS2812_ARB_FIXED_PRIORITY_EN: lowest set index wins, ptr ignored.
module ws2812_rr_select #(
  parameter int SOURCES = 2
) (
  input  logic [SOURCES-1:0]         trigger,
  input  logic [$clog2(SOURCES)-1:0] ptr,
  output logic [$clog2(SOURCES)-1:0] idx,
  output logic                       valid
);
  localparam int IDW = $clog2(SOURCES);

`ifdef WS2812_ARB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan downward so the lowest set index is the last (winning) write.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = SOURCES - 1; i >= 0; i--) begin
      if (trigger[i]) begin
        idx   = IDW'(i);
        valid = 1'b1;
      end
    end
  end
`else
  // Walk ptr, ptr+1, ... with wrap; first set trigger wins.
  always_comb begin
    int j;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < SOURCES; i++) begin
      j = int'(ptr) + i;
      if (j >= SOURCES) j = j - SOURCES;
      if (!valid && trigger[j]) begin
        idx   = IDW'(j);
        valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ws2812_frame_arbiter.sv
// Shares one WS2812 strip driver between SOURCES pattern generators.
// A granted source streams one full frame (LEDS*3 bytes), then the strip
// is held idle for LATCH_CYCLES before the next grant.
// Build option: WS2812_ARB_FIXED_PRIORITY_EN selects fixed priority
// (lowest index) instead of round-robin.
module ws2812_frame_arbiter
  import ws2812_frame_arbiter_pkg::*;
#(
  parameter int SOURCES      = 2,
  parameter int LEDS         = 32,
  parameter int LATCH_CYCLES = 800000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SOURCES-1:0]         src_trigger,
  input  logic [SOURCES*8-1:0]       src_color,
  output logic [SOURCES-1:0]         src_data_request,
  output logic                       drv_start,
  input  logic                       drv_data_request,
  output logic [7:0]                 drv_color,
  output logic [$clog2(SOURCES)-1:0] grant_id,
  output logic                       frame_active
);
  localparam int IDW         = $clog2(SOURCES);
  localparam int FRAME_BYTES = LEDS * BYTES_PER_LED;
  localparam int BCW         = $clog2(FRAME_BYTES);
  localparam int LCW         = $clog2(LATCH_CYCLES + 1);

  arb_state_e                 state, state_nxt;
  logic [BCW-1:0]             byte_cnt;
  logic [LCW-1:0]             latch_cnt;
  logic [IDW-1:0]             sel_ptr, sel_idx;
  logic                       sel_valid;
  logic [SOURCES-1:0][7:0]    color_lanes;
  logic                       last_byte;

  assign color_lanes = src_color;
  assign last_byte   = (byte_cnt == BCW'(FRAME_BYTES - 1));

  ws2812_rr_select #(.SOURCES(SOURCES)) u_sel (
    .trigger (src_trigger),
    .ptr     (sel_ptr),
    .idx     (sel_idx),
    .valid   (sel_valid)
  );

`ifdef WS2812_ARB_FIXED_PRIORITY_EN
  assign sel_ptr = '0;
`else
  // Pointer holds the index searched first: one past the last winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 sel_ptr <= '0;
    else if (state == ST_IDLE && sel_valid)   sel_ptr <= (sel_idx == IDW'(SOURCES - 1)) ? '0 : sel_idx + 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; triggers only matter in IDLE, data requests only in STREAM.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (sel_valid) state_nxt = ST_GRANT;
      ST_GRANT:  state_nxt = ST_STREAM;
      ST_STREAM: if (drv_data_request && last_byte) state_nxt = ST_LATCH;
      ST_LATCH:  if (latch_cnt == '0) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Grant latch, byte counter and latch-gap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id  <= '0;
      byte_cnt  <= '0;
      latch_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE:   if (sel_valid) grant_id <= sel_idx;
        ST_GRANT:  byte_cnt <= '0;
        ST_STREAM: if (drv_data_request) begin
                     if (last_byte) latch_cnt <= LCW'(LATCH_CYCLES - 1);
                     else           byte_cnt  <= byte_cnt + 1'b1;
                   end
        ST_LATCH:  if (latch_cnt != '0) latch_cnt <= latch_cnt - 1'b1;
        default:   ;
      endcase
    end
  end

  // Driver-side outputs; the byte path is combinational so the driver sees
  // the granted source's byte and the consume strobe in the same cycle.
  always_comb begin
    drv_start        = (state == ST_GRANT);
    frame_active     = (state == ST_GRANT) || (state == ST_STREAM);
    drv_color        = 8'h00;
    src_data_request = '0;
    if (state == ST_STREAM) begin
      drv_color                  = color_lanes[grant_id];
      src_data_request[grant_id] = drv_data_request;
    end
  end

endmodule
